// File: rtl/mm_tile_scheduler.sv
// mm_tile_scheduler: walks the output-tile grid of one matmul job in
// row-major order, issues one command per tile over valid/ready, caps the
// number of in-flight tiles, and pulses done once every tile has retired.

package dims;
  localparam int P_MATRIXSIZE_W = 24;

  typedef struct packed {
    logic [P_MATRIXSIZE_W-1:0] M1dN1;  // tile rows
    logic [P_MATRIXSIZE_W-1:0] M3dN2;  // tile cols
    logic [P_MATRIXSIZE_W-1:0] M2;     // inner length
  } dimensions;
endpackage

module mm_tile_scheduler #(
  parameter int N1                = 4,
  parameter int N2                = 4,
  parameter int P_MATRIXSIZE_W    = dims::P_MATRIXSIZE_W,
  parameter int P_MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  dims::dimensions           dims_i,
  output logic                      busy,
  output logic                      done,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [P_MATRIXSIZE_W-1:0] cmd_row,
  output logic [P_MATRIXSIZE_W-1:0] cmd_col,
  output logic [P_MATRIXSIZE_W-1:0] cmd_klen,
  output logic                      cmd_first,
  output logic                      cmd_last,
  input  logic                      tile_done,
  output logic [3:0]                outstanding,
  output logic                      err
);

  // Array geometry only sanity-checks the configuration; the outstanding
  // counter is 4 bits wide, so the limit must fit below 16.
  if (N1 < 1 || N2 < 1 || P_MAX_OUTSTANDING < 1 || P_MAX_OUTSTANDING > 15) begin : gBadParams
    $error("mm_tile_scheduler: illegal parameter set");
  end

  localparam logic [P_MATRIXSIZE_W-1:0] ONE    = P_MATRIXSIZE_W'(1);
  localparam logic [3:0]                OUTMAX = 4'(P_MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

  stateT                     state, stateNext;
  logic [P_MATRIXSIZE_W-1:0] tileRows, tileCols, kLen;
  logic [P_MATRIXSIZE_W-1:0] row, col;
  logic                      cmdValidQ;
  logic [3:0]                outCnt, outNext;
  logic                      errQ;

  logic fire, colWrap, isLast, zeroJob, accept, spurious;

  assign fire     = cmdValidQ & cmd_ready;
  assign colWrap  = (col == tileCols - ONE);
  assign isLast   = (row == tileRows - ONE) && colWrap;
  assign zeroJob  = (dims_i.M1dN1 == '0) || (dims_i.M3dN2 == '0);
  assign accept   = (state == IDLE) && start;
  // A completion with nothing in flight (and no fire to pair it with) is bogus.
  assign spurious = tile_done && !fire && (outCnt == 4'd0);

  // In-flight count: a fire and a completion in the same cycle cancel out;
  // a spurious completion saturates at zero.
  always_comb begin
    outNext = outCnt;
    if (fire && !tile_done)
      outNext = outCnt + 4'd1;
    else if (!fire && tile_done && outCnt != 4'd0)
      outNext = outCnt - 4'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; DRAIN looks at the post-update count so the last
  // completion reaches DONE on the following cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = zeroJob ? DONE : ISSUE;
      ISSUE:   if (fire && isLast) stateNext = DRAIN;
      DRAIN:   if (outNext == 4'd0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Job descriptor, tile indices, command valid, in-flight count and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tileRows  <= '0;
      tileCols  <= '0;
      kLen      <= '0;
      row       <= '0;
      col       <= '0;
      cmdValidQ <= 1'b0;
      outCnt    <= 4'd0;
      errQ      <= 1'b0;
    end else begin
      outCnt <= outNext;
      // A pending command holds until it fires; a new one is offered only
      // while the job is still issuing and the post-update count has room.
      cmdValidQ <= (stateNext == ISSUE) &&
                   ((cmdValidQ && !fire) || (outNext < OUTMAX));
      if (accept) begin
        tileRows <= P_MATRIXSIZE_W'(dims_i.M1dN1);
        tileCols <= P_MATRIXSIZE_W'(dims_i.M3dN2);
        kLen     <= P_MATRIXSIZE_W'(dims_i.M2);
        row      <= '0;
        col      <= '0;
      end else if (fire) begin
        if (colWrap) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end
      // A spurious completion wins over the clear from a same-cycle start.
      if (spurious)    errQ <= 1'b1;
      else if (accept) errQ <= 1'b0;
    end
  end

  assign cmd_valid   = cmdValidQ;
  assign cmd_row     = row;
  assign cmd_col     = col;
  assign cmd_klen    = kLen;
  assign cmd_first   = cmdValidQ && (row == '0) && (col == '0);
  assign cmd_last    = cmdValidQ && isLast;
  assign outstanding = outCnt;
  assign err         = errQ;

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// Directed bench for mm_tile_scheduler: a scoreboard of expected commands
// is filled when a job is started and drained as the DUT fires commands.
module tb_mm_tile_scheduler;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dims::dimensions dimsIn;
  logic startA = 0, startB = 0, readyMan = 0, readyRnd = 0, randReady = 0;
  logic readyB = 0, tdMan = 0, tdAuto = 0, tdB = 0;
  logic readyA, tdA;
  assign readyA = randReady ? readyRnd : readyMan;
  assign tdA    = tdAuto | tdMan;

  logic busyA, doneA, validA, firstA, lastA, errA;
  logic [W-1:0] rowA, colA, klenA;
  logic [3:0] outA;
  logic busyB, doneB, validB, firstB, lastB, errB;
  logic [W-1:0] rowB, colB, klenB;
  logic [3:0] outB;

  mm_tile_scheduler #(.P_MAX_OUTSTANDING(4)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .dims_i(dimsIn),
    .busy(busyA), .done(doneA), .cmd_valid(validA), .cmd_ready(readyA),
    .cmd_row(rowA), .cmd_col(colA), .cmd_klen(klenA), .cmd_first(firstA),
    .cmd_last(lastA), .tile_done(tdA), .outstanding(outA), .err(errA));

  mm_tile_scheduler #(.P_MAX_OUTSTANDING(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .dims_i(dimsIn),
    .busy(busyB), .done(doneB), .cmd_valid(validB), .cmd_ready(readyB),
    .cmd_row(rowB), .cmd_col(colB), .cmd_klen(klenB), .cmd_first(firstB),
    .cmd_last(lastB), .tile_done(tdB), .outstanding(outB), .err(errB));

  int nCmp = 0, nErr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int row;
    int col;
    int klen;
    bit first;
    bit last;
  } expCmd;
  expCmd sbq[$];

  function automatic void pushJob(input int rows, input int cols, input int k);
    expCmd e;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        e.row = r; e.col = c; e.klen = k;
        e.first = (r == 0 && c == 0);
        e.last  = (r == rows - 1 && c == cols - 1);
        sbq.push_back(e);
      end
  endfunction

  // Monitor: scoreboard, stall stability, done/fire bookkeeping and the
  // auto tile_done generator (completion 3 cycles after each fire).
  int cyc = 0, doneCnt = 0, doneCyc = -1, tdCnt = 0, lastTdCyc = -1;
  int fireCnt = 0, fireCntB = 0;
  logic [7:0] tdPipe = '0;
  bit prevStall = 0;
  logic [W-1:0] pRow, pCol, pKlen;
  logic pFirst, pLast;
  initial forever begin
    expCmd e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prevStall = 0; tdPipe = '0; tdAuto = 1'b0;
    end else begin
      if (prevStall) begin
        chk("stallValid", 64'(validA), 64'd1);
        chk("stallRow", 64'(rowA), 64'(pRow));
        chk("stallCol", 64'(colA), 64'(pCol));
        chk("stallKlen", 64'(klenA), 64'(pKlen));
        chk("stallFlags", 64'({firstA, lastA}), 64'({pFirst, pLast}));
      end
      prevStall = validA && !readyA;
      pRow = rowA; pCol = colA; pKlen = klenA; pFirst = firstA; pLast = lastA;
      if (doneA) begin doneCnt++; doneCyc = cyc; end
      if (validA && readyA) begin
        fireCnt++;
        chk("cmdExpected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("cmdRow", 64'(rowA), 64'(e.row));
          chk("cmdCol", 64'(colA), 64'(e.col));
          chk("cmdKlen", 64'(klenA), 64'(e.klen));
          chk("cmdFlags", 64'({firstA, lastA}), 64'({e.first, e.last}));
        end
      end
      if (validB && readyB) fireCntB++;
      tdPipe = tdPipe >> 1;
      if (validA && readyA) tdPipe[3] = 1'b1;
      tdAuto = tdPipe[0];
      if (tdAuto) begin tdCnt++; lastTdCyc = cyc; end
    end
  end

  // Random backpressure source, used only while randReady is set.
  initial forever begin
    @(posedge clk); #1;
    readyRnd = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseStartA();
    startA = 1'b1; tick(1); startA = 1'b0;
  endtask

  task automatic setDims(input int r, input int c, input int k);
    dimsIn.M1dN1 = W'(r); dimsIn.M3dN2 = W'(c); dimsIn.M2 = W'(k);
  endtask

  task automatic waitDoneA(input string tag, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (doneA) seen = 1;
    end
    chk(tag, 64'(seen), 64'd1);
    tick(1);
  endtask

  task automatic checkIdleA(input string tag);
    chk({tag, ".busy"}, 64'(busyA), 64'd0);
    chk({tag, ".done"}, 64'(doneA), 64'd0);
    chk({tag, ".valid"}, 64'(validA), 64'd0);
    chk({tag, ".row"}, 64'(rowA), 64'd0);
    chk({tag, ".col"}, 64'(colA), 64'd0);
    chk({tag, ".klen"}, 64'(klenA), 64'd0);
    chk({tag, ".flags"}, 64'({firstA, lastA}), 64'd0);
    chk({tag, ".out"}, 64'(outA), 64'd0);
    chk({tag, ".err"}, 64'(errA), 64'd0);
  endtask

  int d0, f0;

  initial begin
    setDims(0, 0, 0);
    // Reset state
    tick(3);
    checkIdleA("reset");
    rst_n = 1'b1;
    tick(2);

    // Basic 2x3 job, always ready, completions 3 cycles after each fire
    setDims(2, 3, 64);
    pushJob(2, 3, 64);
    d0 = doneCnt; f0 = fireCnt; tdCnt = 0;
    readyMan = 1'b1;
    pulseStartA();
    @(negedge clk);
    chk("t1.busyAfterStart", 64'(busyA), 64'd1);
    chk("t1.validAfterStart", 64'(validA), 64'd1);
    waitDoneA("t1.doneSeen", 100);
    tick(3);
    chk("t1.doneCount", 64'(doneCnt - d0), 64'd1);
    chk("t1.fires", 64'(fireCnt - f0), 64'd6);
    chk("t1.tileDones", 64'(tdCnt), 64'd6);
    chk("t1.doneLatency", 64'(doneCyc), 64'(lastTdCyc + 1));
    chk("t1.sbEmpty", 64'(sbq.size()), 64'd0);
    chk("t1.idleBusy", 64'(busyA), 64'd0);
    chk("t1.idleOut", 64'(outA), 64'd0);

    // Same job under random backpressure
    pushJob(2, 3, 64);
    d0 = doneCnt; f0 = fireCnt;
    randReady = 1'b1;
    pulseStartA();
    waitDoneA("t2.doneSeen", 400);
    randReady = 1'b0;
    tick(3);
    chk("t2.doneCount", 64'(doneCnt - d0), 64'd1);
    chk("t2.fires", 64'(fireCnt - f0), 64'd6);
    chk("t2.sbEmpty", 64'(sbq.size()), 64'd0);

    // Outstanding limit of 2 with completions withheld
    readyB = 1'b1;
    startB = 1'b1; tick(1); startB = 1'b0;
    tick(6);
    @(negedge clk);
    chk("t3.fires", 64'(fireCntB), 64'd2);
    chk("t3.validLow", 64'(validB), 64'd0);
    chk("t3.outstanding", 64'(outB), 64'd2);
    tick(1);
    tdB = 1'b1; tick(1); tdB = 1'b0;
    @(negedge clk);
    chk("t3.thirdValid", 64'(validB), 64'd1);
    chk("t3.thirdRow", 64'(rowB), 64'd0);
    chk("t3.thirdCol", 64'(colB), 64'd2);
    tick(1);

    // Zero-tile jobs: M3dN2=0, then M1dN1=0
    for (int z = 0; z < 2; z++) begin
      if (z == 0) setDims(2, 0, 8); else setDims(0, 3, 8);
      f0 = fireCnt;
      pulseStartA();
      @(negedge clk);
      chk("t4.done", 64'(doneA), 64'd1);
      chk("t4.busy", 64'(busyA), 64'd1);
      chk("t4.valid", 64'(validA), 64'd0);
      @(negedge clk);
      chk("t4.doneFall", 64'(doneA), 64'd0);
      chk("t4.busyFall", 64'(busyA), 64'd0);
      chk("t4.noFires", 64'(fireCnt - f0), 64'd0);
      tick(1);
    end

    // Spurious tile_done in IDLE, then a 1x1 job that clears err
    tdMan = 1'b1; tick(1); tdMan = 1'b0;
    @(negedge clk);
    chk("t5.errSet", 64'(errA), 64'd1);
    chk("t5.outZero", 64'(outA), 64'd0);
    tick(1);
    setDims(1, 1, 5);
    pushJob(1, 1, 5);
    pulseStartA();
    @(negedge clk);
    chk("t5.errCleared", 64'(errA), 64'd0);
    waitDoneA("t5.doneSeen", 50);
    tick(2);
    chk("t5.sbEmpty", 64'(sbq.size()), 64'd0);

    // start during ISSUE with new dims is ignored
    readyMan = 1'b0;
    setDims(2, 3, 64);
    pushJob(2, 3, 64);
    d0 = doneCnt; f0 = fireCnt;
    pulseStartA();
    tick(2);
    setDims(1, 1, 9);
    pulseStartA();
    @(negedge clk);
    chk("t6.klenHeld", 64'(klenA), 64'd64);
    tick(2);
    readyMan = 1'b1;
    waitDoneA("t6.doneSeen", 100);
    tick(3);
    chk("t6.fires", 64'(fireCnt - f0), 64'd6);
    chk("t6.doneCount", 64'(doneCnt - d0), 64'd1);
    chk("t6.sbEmpty", 64'(sbq.size()), 64'd0);

    // Reset mid-job aborts without done
    readyMan = 1'b0;
    setDims(2, 3, 64);
    d0 = doneCnt;
    pulseStartA();
    tick(2);
    chk("t7.busyBefore", 64'(busyA), 64'd1);
    chk("t7.validBefore", 64'(validA), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkIdleA("t7.abort");
    chk("t7.outB", 64'(outB), 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("t7.noDone", 64'(doneCnt - d0), 64'd0);
    chk("t7.idleBusy", 64'(busyA), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
